// File: rtl/counter.sv
// rtl/counter.sv - up-counter with terminal-count flag and registered wrap pulse
// Optional build macro COUNTER_SATURATE_EN: hold at MAX_VALUE instead of wrapping.
module counter #(
  parameter int              WIDTH     = 2,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] max_c = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] one_c = WIDTH'(1);

  logic             at_max;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;

  assign at_max = (out == max_c);

  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    if (enable) begin
      if (at_max) begin
`ifdef COUNTER_SATURATE_EN
        out_nxt  = out;
`else
        out_nxt  = '0;
        wrap_nxt = 1'b1;
`endif
      end else begin
        out_nxt = out + one_c;
`ifdef COUNTER_SATURATE_EN
        // saturation is only ever entered from MAX_VALUE-1, so this fires once
        wrap_nxt = (out_nxt == max_c);
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= out_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign tc = at_max & enable & reset;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter (WIDTH=2 default and WIDTH=4/MAX_VALUE=9)
module tb_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] a_out;
  logic       a_tc, a_wrap;
  logic [3:0] b_out;
  logic       b_tc, b_wrap;

  always #5 clk = ~clk;

  counter u_a (.clock(clk), .reset(rst), .enable(en), .out(a_out), .tc(a_tc), .wrap(a_wrap));
  counter #(.WIDTH(4), .MAX_VALUE(9)) u_b (.clock(clk), .reset(rst), .enable(en), .out(b_out), .tc(b_tc), .wrap(b_wrap));

`ifdef COUNTER_SATURATE_EN
  localparam bit sat = 1'b1;
`else
  localparam bit sat = 1'b0;
`endif

  typedef struct {int a_out; int a_wrap; int b_out; int b_wrap;} exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ma_out = 0, ma_wrap = 0, mb_out = 0, mb_wrap = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int mx, inout int o, inout int w, input bit r, input bit e);
    if (!r) begin
      o = 0; w = 0;
    end else if (!e) begin
      w = 0;
    end else if (o == mx) begin
      if (sat) w = 0;
      else begin o = 0; w = 1; end
    end else begin
      o = o + 1;
      w = (sat && o == mx) ? 1 : 0;
    end
  endtask

  task automatic step(input bit r, input bit e);
    exp_t x;
    @(negedge clk);
    rst = r; en = e;
    #1;
    check("tc_a", int'(a_tc), (r && e && ma_out == 3) ? 1 : 0);
    check("tc_b", int'(b_tc), (r && e && mb_out == 9) ? 1 : 0);
    check("hold_a", int'(a_out), ma_out);
    model(3, ma_out, ma_wrap, r, e);
    model(9, mb_out, mb_wrap, r, e);
    x.a_out = ma_out; x.a_wrap = ma_wrap; x.b_out = mb_out; x.b_wrap = mb_wrap;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      check("out_a", int'(a_out), x.a_out);
      check("wrap_a", int'(a_wrap), x.a_wrap);
      check("out_b", int'(b_out), x.b_out);
      check("wrap_b", int'(b_wrap), x.b_wrap);
    end
  endtask

  int seq_a[10];
  int wraps;

  initial begin
    rst = 1'b0; en = 1'b1;

    step(0, 1); step(0, 1);
    check("rst_out", int'(a_out), 0);
    check("rst_wrap", int'(a_wrap), 0);
    check("rst_tc", int'(a_tc), 0);

    if (sat) seq_a = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3};
    else     seq_a = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    for (int i = 0; i < 10; i++) begin
      step(1, 1);
      check($sformatf("seq_a[%0d]", i), int'(a_out), seq_a[i]);
    end

    step(0, 1);
    step(1, 1); step(1, 1);
    for (int i = 0; i < 5; i++) step(1, 0);
    check("freeze_out", int'(a_out), 2);
    check("freeze_tc", int'(a_tc), 0);
    step(1, 1);
    check("resume_out", int'(a_out), 3);
    #1;
    check("resume_tc", int'(a_tc), 1);

    step(0, 1);
    check("midrst_out", int'(a_out), 0);
    check("midrst_wrap", int'(a_wrap), 0);

    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1);
      wraps += int'(b_wrap);
    end
    check("b_final", int'(b_out), sat ? 9 : 2);
    check("b_wraps", wraps, 1);

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
